// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: evaluates the CON flip-flop, forms PC + C through Y/ALU/Z,
// writes PC only for a taken branch, and keeps saturating taken / not-taken counts.
module branch_sequencer #(
    parameter logic [4:0] OPC_BR        = 5'b10010,
    parameter int         SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        conditionMet,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        illegal,
    output logic        Gra,
    output logic        Rout,
    output logic        CONin,
    output logic        PCout,
    output logic        Yin,
    output logic        Cout,
    output logic        ADD,
    output logic        Zin,
    output logic        Zlowout,
    output logic        PCin,
    output logic [15:0] taken_count,
    output logic [15:0] nottaken_count
);

    // state  | meaning
    // IDLE   | waiting for start; no strobes
    // EVAL   | Ra onto the bus, load the condition flip-flop
    // SETTLE | wait SETTLE_CYCLES for conditionMet, sample on the last edge
    // ADDR   | PC into Y
    // SUM    | Y + C into Z
    // WRITE  | Z onto the bus, PC loads only for a taken branch
    // DONE   | one-cycle completion pulse with outcome flags
    localparam logic [2:0] STATE_IDLE   = 3'd0;
    localparam logic [2:0] STATE_EVAL   = 3'd1;
    localparam logic [2:0] STATE_SETTLE = 3'd2;
    localparam logic [2:0] STATE_ADDR   = 3'd3;
    localparam logic [2:0] STATE_SUM    = 3'd4;
    localparam logic [2:0] STATE_WRITE  = 3'd5;
    localparam logic [2:0] STATE_DONE   = 3'd6;

    localparam logic [2:0]  SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);
    localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

    logic [2:0] state;
    logic [2:0] nextState;
    logic       condQ;
    logic       illQ;
    logic [2:0] settleCnt;
    logic       settleDone;
    logic [4:0] opcode;
    logic [3:0] c2;
    logic       requestOk;
    logic       unusedIrBits;

    assign opcode       = ir[31:27];
    assign c2           = ir[22:19];
    // Legal conditions are brzr/brnz/brpl/brmi: C2 = 0000, 0100, 1000, 1100.
    assign requestOk    = (opcode == OPC_BR) && (c2[1:0] == 2'b00);
    assign settleDone   = (settleCnt == 3'd0);
    assign unusedIrBits = ^{ir[26:23], ir[18:0]};

    always_comb begin
        nextState = state;
        case (state)
            STATE_IDLE: begin
                if (start) begin
                    nextState = requestOk ? STATE_EVAL : STATE_DONE;
                end
            end
            STATE_EVAL:   nextState = STATE_SETTLE;
            STATE_SETTLE: begin
                if (settleDone) begin
                    nextState = STATE_ADDR;
                end
            end
            STATE_ADDR:   nextState = STATE_SUM;
            STATE_SUM:    nextState = STATE_WRITE;
            STATE_WRITE:  nextState = STATE_DONE;
            STATE_DONE:   nextState = STATE_IDLE;
            default:      nextState = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state          <= STATE_IDLE;
            condQ          <= 1'b0;
            illQ           <= 1'b0;
            settleCnt      <= 3'd0;
            taken_count    <= 16'd0;
            nottaken_count <= 16'd0;
        end else begin
            state <= nextState;
            case (state)
                STATE_IDLE: begin
                    if (start) begin
                        illQ <= !requestOk;
                        if (!requestOk) begin
                            condQ <= 1'b0;
                        end
                    end
                end
                STATE_EVAL: begin
                    settleCnt <= SETTLE_LOAD;
                end
                STATE_SETTLE: begin
                    if (settleDone) begin
                        condQ <= conditionMet;
                    end else begin
                        settleCnt <= settleCnt - 3'd1;
                    end
                end
                STATE_DONE: begin
                    // Outcome is counted on the way out of DONE; illegal requests never count.
                    if (!illQ) begin
                        if (condQ) begin
                            if (taken_count != COUNT_MAX) begin
                                taken_count <= taken_count + 16'd1;
                            end
                        end else begin
                            if (nottaken_count != COUNT_MAX) begin
                                nottaken_count <= nottaken_count + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state != STATE_IDLE);
        done    = 1'b0;
        taken   = 1'b0;
        illegal = 1'b0;
        Gra     = 1'b0;
        Rout    = 1'b0;
        CONin   = 1'b0;
        PCout   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ADD     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        PCin    = 1'b0;
        case (state)
            STATE_EVAL: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                CONin = 1'b1;
            end
            STATE_ADDR: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            STATE_SUM: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            STATE_WRITE: begin
                Zlowout = 1'b1;
                PCin    = condQ;
            end
            STATE_DONE: begin
                done    = 1'b1;
                taken   = condQ;
                illegal = illQ;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: cycle-by-cycle strobe checks, illegal requests,
// back-to-back and busy starts, mid-sequence clear, a 3-cycle settle variant and counter saturation.
module tb_branch_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic        start3;
    logic [31:0] ir;
    logic        conditionMet;

    logic busy, done, taken, illegal, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin;
    logic [15:0] takenCount, notTakenCount;
    logic busy3, done3, taken3, illegal3, Gra3, Rout3, CONin3, PCout3, Yin3, Cout3, ADD3, Zin3,
          Zlowout3, PCin3;
    logic [15:0] takenCount3, notTakenCount3;

    int checks = 0;
    int errors = 0;

    // {2'b00, busy, done, taken, illegal, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin}
    logic [15:0] vec, vec3;
    assign vec  = {2'b00, busy, done, taken, illegal, Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin,
                   Zlowout, PCin};
    assign vec3 = {2'b00, busy3, done3, taken3, illegal3, Gra3, Rout3, CONin3, PCout3, Yin3, Cout3,
                   ADD3, Zin3, Zlowout3, PCin3};

    localparam logic [15:0] V_IDLE     = 16'b00_00000000000000;
    localparam logic [15:0] V_EVAL     = 16'b00_10001110000000;
    localparam logic [15:0] V_SETTLE   = 16'b00_10000000000000;
    localparam logic [15:0] V_ADDR     = 16'b00_10000001100000;
    localparam logic [15:0] V_SUM      = 16'b00_10000000011100;
    localparam logic [15:0] V_WRITE_T  = 16'b00_10000000000011;
    localparam logic [15:0] V_WRITE_N  = 16'b00_10000000000010;
    localparam logic [15:0] V_DONE_T   = 16'b00_11100000000000;
    localparam logic [15:0] V_DONE_N   = 16'b00_11000000000000;
    localparam logic [15:0] V_DONE_ILL = 16'b00_11010000000000;

    localparam logic [31:0] IR_BRZR  = {5'b10010, 4'h1, 4'b0000, 19'd5};
    localparam logic [31:0] IR_BRNZ  = {5'b10010, 4'h3, 4'b0100, 19'd7};
    localparam logic [31:0] IR_BRPL  = {5'b10010, 4'h4, 4'b1000, 19'd9};
    localparam logic [31:0] IR_BRMI  = {5'b10010, 4'h2, 4'b1100, 19'd0};
    localparam logic [31:0] IR_BADC2 = {5'b10010, 4'h1, 4'b0010, 19'd0};
    localparam logic [31:0] IR_BADOP = {5'b00000, 4'h1, 4'b0000, 19'd0};

    branch_sequencer #(.OPC_BR(5'b10010), .SETTLE_CYCLES(1)) dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir), .conditionMet(conditionMet),
        .busy(busy), .done(done), .taken(taken), .illegal(illegal),
        .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin), .Cout(Cout),
        .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin),
        .taken_count(takenCount), .nottaken_count(notTakenCount)
    );

    branch_sequencer #(.OPC_BR(5'b10010), .SETTLE_CYCLES(3)) dut3 (
        .clock(clock), .clear(clear), .start(start3), .ir(ir), .conditionMet(conditionMet),
        .busy(busy3), .done(done3), .taken(taken3), .illegal(illegal3),
        .Gra(Gra3), .Rout(Rout3), .CONin(CONin3), .PCout(PCout3), .Yin(Yin3), .Cout(Cout3),
        .ADD(ADD3), .Zin(Zin3), .Zlowout(Zlowout3), .PCin(PCin3),
        .taken_count(takenCount3), .nottaken_count(notTakenCount3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic launch(input logic [31:0] irv);
        start = 1'b1;
        ir    = irv;
        @(negedge clock);
    endtask

    // Called in cycle 1 of a legal branch; returns in cycle 6 (DONE).
    // conditionMet carries condV only during the sample cycle, its inverse elsewhere.
    task automatic followLegal(input string tag, input logic condV, input logic holdStart,
                               input logic pulses);
        conditionMet = !condV;
        if (!holdStart) start = 1'b0;
        check({tag, ".eval"}, vec, V_EVAL);
        @(negedge clock);
        conditionMet = condV;
        if (pulses) start = 1'b1;
        check({tag, ".settle"}, vec, V_SETTLE);
        @(negedge clock);
        conditionMet = !condV;
        if (pulses) start = 1'b0;
        check({tag, ".addr"}, vec, V_ADDR);
        @(negedge clock);
        if (pulses) start = 1'b1;
        check({tag, ".sum"}, vec, V_SUM);
        @(negedge clock);
        if (pulses) start = 1'b0;
        check({tag, ".write"}, vec, condV ? V_WRITE_T : V_WRITE_N);
        @(negedge clock);
        check({tag, ".done"}, vec, condV ? V_DONE_T : V_DONE_N);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear        = 1'b1;
        start        = 1'b0;
        start3       = 1'b0;
        ir           = 32'd0;
        conditionMet = 1'b0;
        repeat (2) @(negedge clock);
        check("reset.vec", vec, V_IDLE);
        check("reset.taken_count", takenCount, 16'd0);
        check("reset.nottaken_count", notTakenCount, 16'd0);
        check("reset.vec3", vec3, V_IDLE);
        clear = 1'b0;
        @(negedge clock);

        // taken brzr
        launch(IR_BRZR);
        followLegal("brzr", 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("brzr.idle", vec, V_IDLE);
        check("brzr.taken_count", takenCount, 16'd1);
        check("brzr.nottaken_count", notTakenCount, 16'd0);

        // not-taken brmi
        launch(IR_BRMI);
        followLegal("brmi", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("brmi.idle", vec, V_IDLE);
        check("brmi.taken_count", takenCount, 16'd1);
        check("brmi.nottaken_count", notTakenCount, 16'd1);

        // illegal C2 and illegal opcode
        conditionMet = 1'b1;
        launch(IR_BADC2);
        start = 1'b0;
        check("badc2.done", vec, V_DONE_ILL);
        @(negedge clock);
        check("badc2.idle", vec, V_IDLE);
        launch(IR_BADOP);
        start = 1'b0;
        check("badop.done", vec, V_DONE_ILL);
        @(negedge clock);
        check("badop.idle", vec, V_IDLE);
        check("illegal.taken_count", takenCount, 16'd1);
        check("illegal.nottaken_count", notTakenCount, 16'd1);

        // start pulses during SETTLE and SUM are ignored
        launch(IR_BRNZ);
        followLegal("brnz_pulse", 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        check("brnz_pulse.idle1", vec, V_IDLE);
        @(negedge clock);
        check("brnz_pulse.idle2", vec, V_IDLE);
        check("brnz_pulse.taken_count", takenCount, 16'd2);

        // start held high: second EVAL follows exactly one IDLE cycle after DONE
        launch(IR_BRPL);
        followLegal("b2b_a", 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        check("b2b.gap_idle", vec, V_IDLE);
        @(negedge clock);
        followLegal("b2b_b", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("b2b.idle", vec, V_IDLE);
        check("b2b.taken_count", takenCount, 16'd3);
        check("b2b.nottaken_count", notTakenCount, 16'd2);

        // SETTLE_CYCLES=3: sample on the last settle edge, done in cycle 8
        conditionMet = 1'b0;
        start3       = 1'b1;
        ir           = IR_BRNZ;
        @(negedge clock);
        start3 = 1'b0;
        check("s3.c1", vec3, V_EVAL);
        @(negedge clock);
        check("s3.c2", vec3, V_SETTLE);
        @(negedge clock);
        check("s3.c3", vec3, V_SETTLE);
        @(negedge clock);
        conditionMet = 1'b1;
        check("s3.c4", vec3, V_SETTLE);
        @(negedge clock);
        conditionMet = 1'b0;
        check("s3.c5", vec3, V_ADDR);
        @(negedge clock);
        check("s3.c6", vec3, V_SUM);
        @(negedge clock);
        check("s3.c7", vec3, V_WRITE_T);
        @(negedge clock);
        check("s3.c8", vec3, V_DONE_T);
        @(negedge clock);
        check("s3.c9", vec3, V_IDLE);
        check("s3.taken_count", takenCount3, 16'd1);
        check("s3.nottaken_count", notTakenCount3, 16'd0);
        check("s3.main_idle", vec, V_IDLE);

        // clear during SUM
        conditionMet = 1'b1;
        launch(IR_BRZR);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("midclr.sum", vec, V_SUM);
        clear = 1'b1;
        @(negedge clock);
        check("midclr.vec", vec, V_IDLE);
        check("midclr.taken_count", takenCount, 16'd0);
        check("midclr.nottaken_count", notTakenCount, 16'd0);
        check("midclr.taken_count3", takenCount3, 16'd0);
        clear = 1'b0;
        @(negedge clock);
        check("midclr.after1", vec, V_IDLE);
        @(negedge clock);
        check("midclr.after2", vec, V_IDLE);
        launch(IR_BRZR);
        followLegal("postclr", 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("postclr.taken_count", takenCount, 16'd1);

        // saturation: preload near the top, then drive taken branches past it
        force dut.taken_count = 16'hFFFE;
        @(negedge clock);
        release dut.taken_count;
        launch(IR_BRZR);
        followLegal("sat1", 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("sat1.taken_count", takenCount, 16'hFFFF);
        launch(IR_BRZR);
        followLegal("sat2", 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check("sat2.taken_count", takenCount, 16'hFFFF);
        check("sat2.nottaken_count", notTakenCount, 16'd0);
        launch(IR_BRMI);
        followLegal("sat3", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("sat3.taken_count", takenCount, 16'hFFFF);
        check("sat3.nottaken_count", notTakenCount, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
